shiftrow_fwd_pipe: RTL and testbench



---
 rtl/shiftrow_fwd_pipe.sv | 94 +++++++++
 tb/tb_shiftrow_fwd_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftrow_fwd_pipe.sv
// Forward (encryption) AES ShiftRows for Nb=4 and Nb=8 states, with the
// shifted state buffered in a small valid/ready output FIFO.

// One state row: byte rotate-left by the row's offset, computed for both widths.
module shiftrow_row #(
  parameter int ROW = 0
) (
  input  logic [31:0] s32,
  input  logic [63:0] s64,
  output logic [31:0] r32,
  output logic [63:0] r64
);
  // Offsets in bytes; ROW 3 is the top (unshifted) row.
  localparam int R4 = 3 - ROW;
  localparam int R8 = (ROW == 0) ? 4 : (ROW == 1) ? 3 : (ROW == 2) ? 1 : 0;

  logic [63:0]  dbl32;
  logic [127:0] dbl64;

  assign dbl32 = {s32, s32};
  assign dbl64 = {s64, s64};
  assign r32   = dbl32[63-8*R4 -: 32];
  assign r64   = dbl64[127-8*R8 -: 64];
endmodule

module shiftrow_fwd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [255:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_mode,
  output logic [255:0]               out_data,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic         mode;
    logic [255:0] data;
  } entry_t;

  logic [3:0][31:0] rot128;
  logic [3:0][63:0] rot256;
  entry_t           wr_entry;
  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  for (genvar r = 0; r < 4; r++) begin : g_row
    shiftrow_row #(.ROW(r)) u_row (
      .s32 (in_data[32*r +: 32]),
      .s64 (in_data[64*r +: 64]),
      .r32 (rot128[r]),
      .r64 (rot256[r])
    );
  end

  // Transform happens before the FIFO so the head entry is ready to drive out.
  assign wr_entry.mode = in_mode;
  assign wr_entry.data = in_mode ? rot256 : {128'b0, rot128};

  assign in_ready  = (occupancy < CW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Gate by out_valid so an empty FIFO never exposes a stale entry.
  assign out_data  = out_valid ? mem[rd_ptr].data : '0;
  assign out_mode  = out_valid ? mem[rd_ptr].mode : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occupancy <= occupancy + CW'(1);
      else if (pop && !push) occupancy <= occupancy - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: tb/tb_shiftrow_fwd_pipe.sv
// Self-checking bench for shiftrow_fwd_pipe: vector table, stall/reset
// sequences, and a scoreboard that also checks the inverse round trip.
module tb_shiftrow_fwd_pipe;
  localparam int DEPTH = 2;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic         in_mode = 0;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 0;
  logic         out_mode;
  logic [255:0] out_data;
  logic [$clog2(DEPTH):0] occupancy;

  shiftrow_fwd_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int popped = 0;

  logic [256:0] exp_q [$];
  logic [255:0] orig_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level AES model: row i (0 = top) rotates left by its Rijndael offset.
  function automatic int off(input int i, input int nb);
    if (nb == 4) return i;
    return (i < 2) ? i : i + 1;
  endfunction

  function automatic logic [255:0] xform(input logic m, input logic [255:0] s, input bit inv);
    logic [255:0] r = '0;
    int nb = m ? 8 : 4;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < nb; c++) begin
        int base = (3 - i) * nb * 8;
        int sc = inv ? (c - off(i, nb) + nb) % nb : (c + off(i, nb)) % nb;
        r[base + (nb - 1 - c) * 8 +: 8] = s[base + (nb - 1 - sc) * 8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] mask(input logic m, input logic [255:0] s);
    return m ? s : {128'b0, s[127:0]};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard: pop/compare the head first, then record any push at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", {255'b0, out_valid}, 256'b0);
        end else begin
          logic [256:0] e;
          logic [255:0] o;
          e = exp_q.pop_front();
          o = orig_q.pop_front();
          chk("sb_data", out_data, e[255:0]);
          chk("sb_mode", {255'b0, out_mode}, {255'b0, e[256]});
          chk("sb_inverse", mask(out_mode, xform(out_mode, out_data, 1'b1)), o);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_mode, xform(in_mode, mask(in_mode, in_data), 1'b0)});
        orig_q.push_back(mask(in_mode, in_data));
        pushed++;
      end
    end
  end

  typedef struct {
    logic         mode;
    logic [255:0] din;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[4];
  logic [255:0] held;
  int base_pop, target;

  initial begin
    vecs[0] = '{1'b0, {128'b0, 128'h00112233_44556677_8899aabb_ccddeeff},
                      {128'b0, 128'h00112233_55667744_aabb8899_ffccddee}};
    vecs[1] = '{1'b1, 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f,
                      256'h00010203_04050607_090a0b0c_0d0e0f08_13141516_17101112_1c1d1e1f_18191a1b};
    vecs[2] = '{1'b0, {128'hdeadbeef_deadbeef_deadbeef_deadbeef, 128'h00112233_44556677_8899aabb_ccddeeff},
                      {128'b0, 128'h00112233_55667744_aabb8899_ffccddee}};
    vecs[3] = '{1'b1, 256'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f_01234567_89abcdef_fedcba98_76543210, '0};
    vecs[3].exp = xform(1'b1, vecs[3].din, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {255'b0, out_valid}, 256'b0);
    chk("rst_in_ready",  {255'b0, in_ready}, 256'b1);
    chk("rst_occupancy", {254'b0, occupancy}, 256'b0);
    chk("rst_out_data",  out_data, 256'b0);
    chk("rst_out_mode",  {255'b0, out_mode}, 256'b0);
    rst_n = 1;
    @(posedge clk); #1;

    // Vector table: one-cycle latency, data and mode on the next cycle
    out_ready = 1;
    for (int v = 0; v < 4; v++) begin
      in_valid = 1; in_mode = vecs[v].mode; in_data = vecs[v].din;
      @(posedge clk); #1;
      in_valid = 0;
      chk($sformatf("vec%0d_valid", v), {255'b0, out_valid}, 256'b1);
      chk($sformatf("vec%0d_mode", v), {255'b0, out_mode}, {255'b0, vecs[v].mode});
      chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drained", v), {254'b0, occupancy}, 256'b0);
    end

    // Stall: fill to DEPTH, third state held upstream, head stable
    out_ready = 0;
    in_valid = 1; in_mode = 0; in_data = rnd256();
    @(posedge clk); #1;
    chk("stall_occ1", {254'b0, occupancy}, 256'd1);
    in_mode = 1; in_data = rnd256();
    @(posedge clk); #1;
    chk("stall_occ2", {254'b0, occupancy}, 256'd2);
    chk("stall_in_ready", {255'b0, in_ready}, 256'b0);
    held = out_data;
    in_mode = 0; in_data = rnd256();
    target = pushed + 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_hold_data", out_data, held);
      chk("stall_hold_occ", {254'b0, occupancy}, 256'd2);
    end
    chk("stall_third_held", 256'(pushed), 256'(target - 1));
    out_ready = 1;
    for (int k = 0; k < 10 && pushed < target; k++) begin
      @(posedge clk); #1;
    end
    chk("stall_third_accepted", 256'(pushed), 256'(target));
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_drained", {254'b0, occupancy}, 256'b0);

    // Streaming with alternating modes: occupancy stays at 1
    base_pop = popped;
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_mode = i[0]; in_data = rnd256();
      @(posedge clk); #1;
      chk("stream_occ", {254'b0, occupancy}, 256'd1);
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("stream_count", 256'(popped - base_pop), 256'd16);

    // Asynchronous reset mid-stream with two entries held
    out_ready = 0;
    in_valid = 1; in_mode = 1; in_data = rnd256();
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0;
    chk("prerst_occ", {254'b0, occupancy}, 256'd2);
    #2;
    rst_n = 0;
    #1;
    exp_q.delete(); orig_q.delete();
    chk("async_rst_valid", {255'b0, out_valid}, 256'b0);
    chk("async_rst_occ", {254'b0, occupancy}, 256'b0);
    chk("async_rst_ready", {255'b0, in_ready}, 256'b1);
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_valid", {255'b0, out_valid}, 256'b0);
    chk("postrst_data", out_data, 256'b0);

    // Random traffic; scoreboard checks forward model and inverse round trip
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_mode = 1'($urandom_range(0, 1));
      in_data = rnd256();
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("final_sb_empty", 256'(exp_q.size()), 256'b0);
    chk("final_occ", {254'b0, occupancy}, 256'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
